// File: rtl/pipe_pkg.sv
// Shared pipeline package: stage bundles, NOP payloads
// and width helpers for buffered pipeline stages.
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

  localparam logic [4:0] NOP_RD = 5'd0;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } id_ex_t;

  localparam id_ex_t ID_EX_NOP = '{
    alu_op: ALU_NOP,
    rd:     NOP_RD,
    rd_we:  1'b0,
    op_a:   32'd0,
    op_b:   32'd0
  };

  localparam int ID_EX_W = $bits(id_ex_t);

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// Buffer storage: one write port, one async read port,
// contents deliberately left unreset.
module pipe_buf_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int PW     = 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage buffer: FIFO of DEPTH entries with
// NOP masking when empty and optional registered ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 2,
  parameter int                READY_REG = 1,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int            PW   = ptr_w(DEPTH);
  localparam int            CW   = cnt_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_rdata;

  // Explicit wrap keeps non-power-of-2 depths exact.
  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);

  if (READY_REG != 0) begin : g_rdy_reg
    assign in_ready = !rst && !w_full;
  end else begin : g_rdy_pass
    assign in_ready = !rst && (!w_full || out_ready);
  end

  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready
                  && !flush && !rst;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? NOP_VALUE : w_rdata;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop)  r_rptr <= nxt(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  pipe_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PW     (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (in_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  a_cnt_range: assert property (
    @(posedge clk) disable iff (rst) r_count <= FULL
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized bench: four buffer configurations run side by
// side against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int N = 4;
  localparam int DEP [N] = '{2, 1, 3, 4};
  localparam int RRG [N] = '{1, 0, 1, 0};
  localparam logic [31:0] NOPV [N] =
    '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0013};

  typedef logic [31:0] q_t [$];

  logic clk = 1'b0;
  logic [N-1:0] rst, flush, iv, ir, ov, ordy, ovr;
  logic [N-1:0][31:0] id, od;
  logic [N-1:0][3:0]  cnt;

  q_t q   [N];
  q_t src [N];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = $clog2(DEP[g] + 1);
    logic [CW-1:0] w_cnt;
    pipe_stage_buf #(
      .DATA_W    (32),
      .DEPTH     (DEP[g]),
      .READY_REG (RRG[g]),
      .NOP_VALUE (NOPV[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .flush     (flush[g]),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (id[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_data  (od[g]),
      .count     (w_cnt)
    );
    assign cnt[g] = 4'(w_cnt);
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
  endtask

  function automatic bit exp_ir(input int k);
    return !rst[k] && (q[k].size() < DEP[k]
        || (RRG[k] == 0 && ordy[k]));
  endfunction

  task automatic tick();
    bit push [N];
    bit pop  [N];
    #1;
    for (int k = 0; k < N; k++) begin
      int sz;
      logic [31:0] e_data;
      sz = q[k].size();
      push[k] = iv[k] && exp_ir(k) && !flush[k];
      pop[k]  = sz != 0 && ordy[k] && !flush[k] && !rst[k];
      if (sz != 0) e_data = q[k][0];
      else e_data = NOPV[k];
      if (chk_en) begin
        check($sformatf("u%0d.count", k),
              32'(cnt[k]), 32'(sz));
        check($sformatf("u%0d.out_valid", k),
              32'(ov[k]), 32'(sz != 0));
        check($sformatf("u%0d.out_data", k),
              od[k], e_data);
        check($sformatf("u%0d.in_ready", k),
              32'(ir[k]), 32'(exp_ir(k)));
      end
    end
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (rst[k] || flush[k]) begin
        q[k].delete();
      end else begin
        if (pop[k]) void'(q[k].pop_front());
        if (push[k]) q[k].push_back(id[k]);
      end
      if (push[k] && !ovr[k]) void'(src[k].pop_front());
    end
    @(negedge clk);
  endtask

  task automatic plan(input int cyc);
    ordy[0] = (cyc >= 4 && cyc < 12) || cyc >= 22;
    rst[0]  = (cyc == 20);
    if (cyc == 12)
      src[0] = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    ordy[1] = 1'b1;
    ordy[2] = 1'($urandom_range(0, 1));
    flush[3] = (cyc == 3);
    ovr[3]   = (cyc == 3);
    ordy[3]  = (cyc >= 8 && cyc < 12) || cyc >= 14;
    rst[3]   = (cyc == 12);
    if (cyc == 3) begin
      iv[3] = 1'b1;
      id[3] = 32'h55;
    end
    if (cyc == 4)
      for (int v = 0; v < 12; v++)
        src[3].push_back(32'h40 + 32'(v));
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (!ovr[k]) begin
        iv[k] = src[k].size() != 0
             && (k != 2 || $urandom_range(0, 3) != 0);
        if (iv[k]) id[k] = src[k][0];
        else id[k] = $urandom();
      end
    end
  endtask

  initial begin
    rst   = '1;
    flush = '0;
    ordy  = '0;
    ovr   = '0;
    iv    = '1;
    id    = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = '0;
    src[0] = '{32'hA, 32'hB, 32'hC};
    for (int v = 1; v <= 8; v++)
      src[1].push_back(32'(v));
    for (int i = 0; i < 20; i++)
      src[2].push_back($urandom());
    src[3] = '{32'h11, 32'h22, 32'h33};
    for (int cyc = 0; cyc < 90; cyc++) begin
      plan(cyc);
      drive();
      tick();
    end
    for (int k = 0; k < N; k++)
      check($sformatf("u%0d.src_drained", k),
            32'(src[k].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
